// File: rtl/ofdm_pkg.sv
// Purpose : shared constants, types and helpers for the OFDM symbol scheduler.
// Latency : n/a (package only).
// Backpres: n/a. Holds carrier geometry helpers, slot-class/FSM enums, LFSR polynomial and seed.
package ofdm_pkg;

  // Default geometry; the scheduler exposes these as overridable parameters.
  localparam int OFDM_SIZE_DEF   = 1024;
  localparam int NUM_CARRIER_DEF = 824;

  // Pilot sign generator: x^7 + x^6 + 1, Fibonacci form, restarted from all-ones.
  localparam logic [6:0] LFSR_TAPS = 7'b110_0000;
  localparam logic [6:0] LFSR_SEED = 7'h7F;

  typedef enum logic [1:0] {
    SC_NULL  = 2'd0,
    SC_PILOT = 2'd1,
    SC_DATA  = 2'd2
  } slot_class_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GAP      = 2'd3
  } sched_state_e;

  // DC slot sits just below the FFT midpoint.
  function automatic int ofdm_mid(input int size);
    return size / 2 - 1;
  endfunction

  // First occupied carrier.
  function automatic int ofdm_left(input int size, input int nc);
    return ofdm_mid(size) - nc / 2;
  endfunction

  // Last occupied carrier.
  function automatic int ofdm_right(input int size, input int nc);
    return ofdm_mid(size) + nc / 2;
  endfunction

  function automatic logic [6:0] lfsr_next(input logic [6:0] s);
    return {s[5:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ofdm_pilot_lfsr.sv
// Purpose : 7-bit pilot sign generator (x^7+x^6+1), reseedable, advances on request.
// Latency : new state visible the cycle after i_seed / i_advance.
// Backpres: none; the caller only asserts i_advance on an accepted pilot slot.
// Ports   : clk, rst (async, active-high); i_seed loads LFSR_SEED (wins over i_advance);
//           i_advance steps the register once; o_lfsr is the current state.
module ofdm_pilot_lfsr
  import ofdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_seed,
  input  logic       i_advance,
  output logic [6:0] o_lfsr
);

  logic [6:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_seed) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_advance) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/ofdm_symbol_scheduler.sv
// Purpose : frame sequencer for the subcarrier mapper; one null/pilot/data descriptor per slot.
// Latency : first descriptor registered one cycle after i_start; one slot per cycle thereafter.
// Backpres: descriptors hold while !i_sc_ready; data slots also wait on i_qam_valid (sets underrun).
// Ports   : clk, rst (async, active-high), i_start, i_abort, i_sc_ready, i_qam_valid;
//           o_sc_valid/o_sc_index/o_sc_null/o_sc_pilot/o_sc_data/o_pilot_sign descriptor,
//           o_sop/o_eop/o_sof/o_eof framing, o_sym_num, o_qam_ready, o_busy, o_underrun.
module ofdm_symbol_scheduler
  import ofdm_pkg::*;
#(
  parameter int OFDM_SIZE        = OFDM_SIZE_DEF,
  parameter int NUM_CARRIER      = NUM_CARRIER_DEF,
  parameter int PILOT_SPACING    = 8,
  parameter int PILOT_SHIFT      = 3,
  parameter int PREAMBLE_SYMBOLS = 2,
  parameter int DATA_SYMBOLS     = 16,
  parameter int GAP_CYCLES       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic                         i_sc_ready,
  output logic                         o_sc_valid,
  output logic [$clog2(OFDM_SIZE)-1:0] o_sc_index,
  output logic                         o_sc_null,
  output logic                         o_sc_pilot,
  output logic                         o_sc_data,
  output logic                         o_pilot_sign,
  output logic                         o_sop,
  output logic                         o_eop,
  output logic                         o_sof,
  output logic                         o_eof,
  output logic [7:0]                   o_sym_num,
  input  logic                         i_qam_valid,
  output logic                         o_qam_ready,
  output logic                         o_busy,
  output logic                         o_underrun
);

  localparam int IW = $clog2(OFDM_SIZE);
  localparam int PW = $clog2(PILOT_SPACING);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [IW-1:0] MID_I    = IW'(ofdm_mid(OFDM_SIZE));
  localparam logic [IW-1:0] LEFT_I   = IW'(ofdm_left(OFDM_SIZE, NUM_CARRIER));
  localparam logic [IW-1:0] RIGHT_I  = IW'(ofdm_right(OFDM_SIZE, NUM_CARRIER));
  localparam logic [IW-1:0] LAST_I   = IW'(OFDM_SIZE - 1);
  localparam logic [PW-1:0] SHIFT_P  = PW'(PILOT_SHIFT % PILOT_SPACING);
  localparam logic [7:0]    PRE_N    = 8'(PREAMBLE_SYMBOLS);
  localparam logic [7:0]    ALL_N    = 8'(PREAMBLE_SYMBOLS + DATA_SYMBOLS);
  localparam logic [7:0]    LAST_SYM = 8'(PREAMBLE_SYMBOLS + DATA_SYMBOLS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  sched_state_e  r_state, w_state_nxt;
  logic [IW-1:0] r_index;
  logic          r_null, r_pilot, r_data, r_sop, r_eop, r_sof, r_eof;
  logic [7:0]    r_sym_num;
  logic [PW-1:0] r_phase;
  logic [GW-1:0] r_gap_cnt;
  logic          r_underrun;

  logic          w_sym_state, w_acc, w_start_acc, w_eop_acc, w_lfsr_adv;
  logic          w_load, w_clear, w_npre;
  logic [IW-1:0] w_nidx;
  slot_class_e   w_cls;
  logic [6:0]    w_lfsr;

  // Spacing is a power of two, so the pilot comb position is just the low
  // bits of the offset from the first occupied carrier.
  function automatic slot_class_e classify(input logic [IW-1:0] idx, input logic pre,
                                           input logic [PW-1:0] ph);
    logic [IW-1:0] off;
    off = idx - LEFT_I;
    if (idx < LEFT_I || idx > RIGHT_I || idx == MID_I) return SC_NULL;
    else if (pre || off[PW-1:0] == ph)                 return SC_PILOT;
    else                                               return SC_DATA;
  endfunction

  assign w_sym_state = (r_state == ST_PREAMBLE) || (r_state == ST_DATA);
  // Data slots are only offered when a QAM sample is there to go with them.
  assign o_sc_valid  = w_sym_state && (!r_data || i_qam_valid);
  assign o_qam_ready = w_sym_state && r_data && i_qam_valid && i_sc_ready;
  assign w_acc       = o_sc_valid && i_sc_ready;
  assign w_start_acc = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_eop_acc   = w_acc && r_eop && !i_abort;
  assign w_lfsr_adv  = w_acc && r_pilot && !i_abort;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_nidx      = r_index + IW'(1);
    w_npre      = (r_state == ST_PREAMBLE);
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_PREAMBLE;
          w_load      = 1'b1;
          w_nidx      = '0;
          w_npre      = 1'b1;
        end
      end
      ST_PREAMBLE, ST_DATA: begin
        if (w_acc) begin
          if (r_eop) begin
            w_state_nxt = ST_GAP;
            w_clear     = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_nidx = '0;
          // r_sym_num already counts the symbol about to start.
          if (r_sym_num < PRE_N) begin
            w_state_nxt = ST_PREAMBLE;
            w_load      = 1'b1;
            w_npre      = 1'b1;
          end else if (r_sym_num < ALL_N) begin
            w_state_nxt = ST_DATA;
            w_load      = 1'b1;
            w_npre      = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b0;
      w_clear     = 1'b1;
    end
  end

  // r_phase is already advanced when a new data symbol is loaded from GAP.
  assign w_cls = classify(w_nidx, w_npre, r_phase);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index <= '0;
      r_null  <= 1'b0;
      r_pilot <= 1'b0;
      r_data  <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_clear) begin
      r_null  <= 1'b0;
      r_pilot <= 1'b0;
      r_data  <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_load) begin
      r_index <= w_nidx;
      r_null  <= (w_cls == SC_NULL);
      r_pilot <= (w_cls == SC_PILOT);
      r_data  <= (w_cls == SC_DATA);
      r_sop   <= (w_nidx == '0);
      r_eop   <= (w_nidx == LAST_I);
      r_sof   <= (r_state == ST_IDLE);
      r_eof   <= (w_nidx == LAST_I) && !w_npre && (r_sym_num == LAST_SYM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sym_num  <= '0;
      r_phase    <= '0;
      r_gap_cnt  <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_start_acc)    r_sym_num <= '0;
      else if (w_eop_acc) r_sym_num <= r_sym_num + 8'd1;

      if (w_start_acc)                            r_phase <= '0;
      else if (w_eop_acc && r_state == ST_DATA)   r_phase <= r_phase + SHIFT_P;

      if (w_eop_acc)               r_gap_cnt <= '0;
      else if (r_state == ST_GAP)  r_gap_cnt <= r_gap_cnt + GW'(1);

      if (w_start_acc)                                   r_underrun <= 1'b0;
      else if (w_sym_state && r_data && !i_qam_valid)    r_underrun <= 1'b1;
    end
  end

  ofdm_pilot_lfsr u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .i_seed    (w_start_acc),
    .i_advance (w_lfsr_adv),
    .o_lfsr    (w_lfsr)
  );

  assign o_sc_index   = r_index;
  assign o_sc_null    = r_null;
  assign o_sc_pilot   = r_pilot;
  assign o_sc_data    = r_data;
  assign o_pilot_sign = r_pilot & w_lfsr[0];
  assign o_sop        = r_sop;
  assign o_eop        = r_eop;
  assign o_sof        = r_sof;
  assign o_eof        = r_eof;
  assign o_sym_num    = r_sym_num;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_underrun   = r_underrun;

endmodule

// File: doc/ofdm_symbol_scheduler.md
Name: ofdm_symbol_scheduler

Overview:
Sequences the OFDM subcarrier mapper frame by frame. Each frame is PREAMBLE_SYMBOLS preamble symbols followed by DATA_SYMBOLS data symbols, with a GAP_CYCLES idle gap after every symbol. For every subcarrier slot the block emits one descriptor: index, null/pilot/data class, and pilot sign. It also pulls QAM samples from the modulator only on data slots. It sits between the QAM/pilot sources and the mapper and replaces free-running count-based slot classification.

Parameters:
OFDM_SIZE, 1024, FFT size; power of two.
NUM_CARRIER, 824, occupied carriers excluding DC; even.
PILOT_SPACING, 8, pilot spacing in data symbols; power of two, >= 2.
PILOT_SHIFT, 3, pilot phase advance per data symbol, modulo PILOT_SPACING.
PREAMBLE_SYMBOLS, 2, preamble symbols per frame; >= 1.
DATA_SYMBOLS, 16, data symbols per frame; >= 1.
GAP_CYCLES, 16, idle cycles after each symbol; >= 1.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle frame request; sampled in IDLE only
abort  in  1  terminate current frame, return to IDLE
sc_ready  in  1  mapper accepts descriptor
sc_valid  out  1  descriptor valid
sc_index  out  log2(OFDM_SIZE)  subcarrier index
sc_null  out  1  null slot (guard or DC)
sc_pilot  out  1  pilot slot
sc_data  out  1  data slot
pilot_sign  out  1  1 = negative pilot
sop  out  1  first slot of symbol (index 0)
eop  out  1  last slot of symbol
sof  out  1  sop of first preamble symbol
eof  out  1  eop of last data symbol
sym_num  out  8  symbol number within frame
qam_valid  in  1  QAM sample available
qam_ready  out  1  QAM sample consumed this cycle
busy  out  1  state != IDLE
underrun  out  1  sticky; set when a data slot waits on qam_valid

Behaviour:
- Constants:
  - MID = OFDM_SIZE/2 - 1 (511).
  - L = MID - NUM_CARRIER/2 (99).
  - R = MID + NUM_CARRIER/2 (923).
- Slot classes:
  - Null when index < L, index > R, or index == MID.
  - Preamble symbols: every non-null slot is a pilot.
  - Data symbols: a non-null slot is a pilot when ((index - L) mod PILOT_SPACING) == phase; otherwise it is data.
- Pilot phase:
  - Reset to 0 at each frame start.
  - After each data symbol, phase <= (phase + PILOT_SHIFT) mod PILOT_SPACING.
  - Tracked with a counter; no divider.
- Pilot sign:
  - 7-bit LFSR, x^7+x^6+1, seeded 7'h7F at frame start.
  - pilot_sign = lfsr[0].
  - LFSR advances on every accepted pilot slot only.
- FSM states: IDLE, PREAMBLE, DATA, GAP.
  - IDLE -> PREAMBLE on start. The first descriptor (index 0, sop=1, sof=1) is registered and valid on the cycle after start.
  - PREAMBLE/DATA -> GAP on the accepted eop.
  - GAP lasts exactly GAP_CYCLES cycles with sc_valid=0. It then goes to PREAMBLE while sym_num < PREAMBLE_SYMBOLS, to DATA while sym_num < PREAMBLE_SYMBOLS + DATA_SYMBOLS, and otherwise to IDLE.
  - sym_num increments on entry to GAP and clears on frame start.
- Handshake:
  - A descriptor is accepted when sc_valid && sc_ready.
  - All descriptor outputs are registered and held stable while sc_valid && !sc_ready.
  - Null and pilot slots: sc_valid=1 unconditionally in symbol states.
  - Data slots: sc_valid = qam_valid; qam_ready = sc_ready && qam_valid. This is the only combinational path.
  - A data slot with qam_valid=0 stalls, sets underrun, and the index does not advance.
- Throughput: one slot per cycle when sc_ready=1 and no QAM stalls.
- Index wrap: OFDM_SIZE-1 is the eop slot; index then returns to 0 for the next symbol.
- abort has priority over everything except rst. Next cycle: state IDLE, sc_valid=0, qam_ready=0; no eof is emitted. underrun is retained.
- start in any state other than IDLE is ignored. start and abort together in IDLE: abort wins.
- underrun clears only on rst or on an accepted start.
- Reset values: every output 0 (busy=0, sc_valid=0, underrun=0, sym_num=0); LFSR 7'h7F; phase 0; state IDLE.
- Reset mid-frame: immediate return to these values; the frame is discarded.

Decomposition:
- Shared package ofdm_pkg: OFDM_SIZE, NUM_CARRIER, MID/L/R derivation functions, the slot-class enum (NULL/PILOT/DATA), LFSR polynomial and seed.
- One sub-module: ofdm_pilot_lfsr, the 7-bit sign generator with seed/advance inputs.

Test Plan:
- Reset, then start with sc_ready=1 and qam_valid=1 -> sof on cycle+1.
  - Preamble symbol: indices 0..98 and 924..1023 null, 511 null, remaining 824 slots pilot.
  - Gap of 16 cycles with sc_valid=0.
- First data symbol with PILOT_SPACING=8 and phase 0 -> pilots at 99, 107, ..., 915; 103 pilots; 511 stays null. The next data symbol has pilots at 102, 110, ...
- qam_valid low for 5 cycles at a data slot -> sc_index held, qam_ready=0, underrun=1. Resume on qam_valid with no skipped index.
- sc_ready low for 3 cycles mid-symbol -> all descriptor outputs and pilot_sign stable; LFSR not advanced.
- Full frame -> eof on index 1023 of sym_num 17, then IDLE with busy=0. Pilot-sign sequence of the first 10 pilots matches the x^7+x^6+1 model from seed 7'h7F.
- abort at index 400 of a data symbol, and rst asserted mid-gap -> both return to IDLE next cycle with sc_valid=0 and no eof. A subsequent start restarts from sym_num 0 with LFSR reseeded.
